// File: rtl/cond_branch_engine_pkg.sv
// cond_branch_pkg: shared state and ALU-op types for the conditional branch engine
package cond_branch_pkg;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {IDLE, CMP, BR, THEN, ELSE, JOIN, DONE} state_e;
  typedef enum logic [1:0] {ADD, SUB, EQ} alu_op_e;
endpackage

// File: rtl/cond_branch_engine_if.sv
// cond_branch_engine_if: host start/done handshake; carries branch counters when SYNTHE_BRANCH_STATS_EN is defined
interface cond_branch_engine_if #(parameter int WIDTH = 64);
  logic r_enable;
  logic [WIDTH-1:0] init_a;
  logic [WIDTH-1:0] init_b;
  logic busy;
  logic w_enable;
  logic [WIDTH-1:0] result;
`ifdef SYNTHE_BRANCH_STATS_EN
  logic [15:0] then_cnt;
  logic [15:0] else_cnt;
  modport master (output r_enable, init_a, init_b, input busy, w_enable, result, then_cnt, else_cnt);
  modport slave (input r_enable, init_a, init_b, output busy, w_enable, result, then_cnt, else_cnt);
`else
  modport master (output r_enable, init_a, init_b, input busy, w_enable, result);
  modport slave (input r_enable, init_a, init_b, output busy, w_enable, result);
`endif
endinterface

// File: rtl/cond_branch_engine_alu.sv
// shared_alu: the single combinational adder/subtractor plus CMP_W-bit equality used by every engine state
module shared_alu
  import cond_branch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CMP_W = WIDTH
) (
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] r,
  output logic             eq
);
  always_comb begin
    r = op == SUB ? x - y : x + y;
    eq = x[CMP_W-1:0] == y[CMP_W-1:0];
  end
endmodule

// File: rtl/cond_branch_engine.sv
// cond_branch_engine: start/compare/branch/join FSM over one shared ALU; SYNTHE_BRANCH_STATS_EN adds branch counters
module cond_branch_engine
  import cond_branch_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int CMP_W  = WIDTH,
  parameter int THEN_K = 1,
  parameter int JOIN_K = 2
) (
  input logic clk,
  input logic rst_n,
  cond_branch_engine_if.slave bus
);
  localparam logic [WIDTH-1:0] THEN_KW = WIDTH'(THEN_K);
  localparam logic [WIDTH-1:0] JOIN_KW = WIDTH'(JOIN_K);
  state_e state;
  alu_op_e op;
  logic [WIDTH-1:0] a, b, acc, res, alu_x, alu_y, alu_r;
  logic cond, alu_eq, busy, w_en, start;
  assign start = bus.r_enable && (state == IDLE || state == DONE);
  assign bus.busy = busy;
  assign bus.w_enable = w_en;
  assign bus.result = res;
  // ALU steering depends only on state; EQ/ELSE reuse the raw a/b operands
  always_comb begin
    op = (state == THEN || state == JOIN) ? ADD : state == ELSE ? SUB : EQ;
    alu_x = state == JOIN ? acc : a;
    alu_y = state == THEN ? THEN_KW : state == JOIN ? JOIN_KW : b;
  end
  shared_alu #(.WIDTH(WIDTH), .CMP_W(CMP_W)) u_alu (
    .op(op), .x(alu_x), .y(alu_y), .r(alu_r), .eq(alu_eq)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      acc <= '0;
      res <= '0;
      cond <= 1'b0;
      busy <= 1'b0;
      w_en <= 1'b0;
    end else if (start) begin
      a <= bus.init_a;
      b <= bus.init_b;
      w_en <= 1'b0;
      busy <= 1'b1;
      state <= CMP;
    end else begin
      case (state)
        CMP: begin
          cond <= alu_eq;
          state <= BR;
        end
        BR: state <= cond ? THEN : ELSE;
        THEN, ELSE: begin
          acc <= alu_r;
          state <= JOIN;
        end
        JOIN: begin
          res <= alu_r;
          w_en <= 1'b1;
          busy <= 1'b0;
          state <= DONE;
        end
        default: ;
      endcase
    end
  end
`ifdef SYNTHE_BRANCH_STATS_EN
  logic [15:0] then_cnt, else_cnt;
  assign bus.then_cnt = then_cnt;
  assign bus.else_cnt = else_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      then_cnt <= '0;
      else_cnt <= '0;
    end else if (state == BR) begin
      then_cnt <= (cond && then_cnt != 16'hFFFF) ? then_cnt + 16'd1 : then_cnt;
      else_cnt <= (!cond && else_cnt != 16'hFFFF) ? else_cnt + 16'd1 : else_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_cond_branch_engine.sv
// tb_cond_branch_engine: directed runs with a scoreboard queue per DUT; dut0 full compare, dut1 CMP_W=1
module tb_cond_branch_engine;
  typedef struct {
    logic [63:0] res;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic pw0 = 1'b0;
  logic pw1 = 1'b0;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  cond_branch_engine_if #(.WIDTH(64)) if0 ();
  cond_branch_engine_if #(.WIDTH(64)) if1 ();
  cond_branch_engine #(.WIDTH(64)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  cond_branch_engine #(.WIDTH(64), .CMP_W(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] res_of(input int d);
    return d != 0 ? if1.result : if0.result;
  endfunction
  function automatic logic busy_of(input int d);
    return d != 0 ? if1.busy : if0.busy;
  endfunction
  function automatic logic we_of(input int d);
    return d != 0 ? if1.w_enable : if0.w_enable;
  endfunction

  task automatic pop_chk(input int d);
    exp_t e;
    if ((d != 0 ? q1.size() : q0.size()) == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done dut%0d: got result %h expected no completion", d, res_of(d));
    end else begin
      e = d != 0 ? q1.pop_front() : q0.pop_front();
      chk($sformatf("result_dut%0d", d), res_of(d), e.res);
      chk($sformatf("latency_dut%0d", d), 64'(cyc), 64'(e.cyc));
    end
  endtask

  always @(negedge clk) begin
    if (if0.w_enable && !pw0) pop_chk(0);
    if (if1.w_enable && !pw1) pop_chk(1);
    pw0 = if0.w_enable;
    pw1 = if1.w_enable;
  end

  task automatic drive(input int d, input logic en, input logic [63:0] a, input logic [63:0] b);
    if (d != 0) begin
      if1.r_enable = en; if1.init_a = a; if1.init_b = b;
    end else begin
      if0.r_enable = en; if0.init_a = a; if0.init_b = b;
    end
  endtask

  task automatic start(input int d, input logic [63:0] a, input logic [63:0] b, input logic [63:0] e, input bit push);
    exp_t x;
    @(negedge clk);
    drive(d, 1'b1, a, b);
    x.res = e;
    x.cyc = cyc + 5;
    if (push) begin
      if (d != 0) q1.push_back(x);
      else q0.push_back(x);
    end
    @(negedge clk);
    drive(d, 1'b0, '0, '0);
  endtask

  task automatic run(input int d, input logic [63:0] a, input logic [63:0] b, input logic [63:0] e);
    logic [63:0] prev;
    prev = res_of(d);
    start(d, a, b, e, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge clk);
      chk("busy_high", 64'(busy_of(d)), 64'd1);
      chk("w_enable_low", 64'(we_of(d)), 64'd0);
      chk("result_hold", res_of(d), prev);
    end
    @(negedge clk);
    chk("busy_clear", 64'(busy_of(d)), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    drive(0, 1'b0, '0, '0);
    drive(1, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(if0.busy), 64'd0);
    chk("rst_w_enable", 64'(if0.w_enable), 64'd0);
    chk("rst_result", if0.result, 64'd0);
    rst_n = 1'b1;
    run(0, 64'd5, 64'd5, 64'd8);
    run(0, 64'd9, 64'd4, 64'd7);
    run(0, ONES, ONES, 64'd2);
    run(0, 64'd1, 64'd3, 64'd0);
    run(1, 64'd2, 64'd4, 64'd5);
    run(1, 64'd3, 64'd4, 64'd1);
    start(0, 64'd100, 64'd7, 64'd95, 1'b1);
    @(negedge clk);
    drive(0, 1'b1, 64'd5, 64'd5);
    @(negedge clk);
    drive(0, 1'b0, '0, '0);
    chk("busy_ignore", 64'(if0.busy), 64'd1);
    repeat (2) @(negedge clk);
    chk("ignored_result", if0.result, 64'd95);
    start(0, 64'd9, 64'd4, 64'd7, 1'b1);
    chk("restart_w_enable_drop", 64'(if0.w_enable), 64'd0);
    chk("restart_result_hold", if0.result, 64'd95);
    repeat (4) @(negedge clk);
    start(0, 64'd5, 64'd5, 64'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", 64'(if0.busy), 64'd0);
    chk("async_w_enable", 64'(if0.w_enable), 64'd0);
    chk("async_result", if0.result, 64'd0);
    chk("async_result_dut1", if1.result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_reset_w_enable", 64'(if0.w_enable), 64'd0);
    chk("post_reset_busy", 64'(if0.busy), 64'd0);
    run(0, 64'd5, 64'd5, 64'd8);
    run(0, 64'd0, 64'd0, 64'd3);
    run(0, 64'd7, 64'd7, 64'd10);
    run(0, 64'd20, 64'd3, 64'd19);
`ifdef SYNTHE_BRANCH_STATS_EN
    chk("then_cnt", 64'(if0.then_cnt), 64'd3);
    chk("else_cnt", 64'(if0.else_cnt), 64'd1);
`endif
    repeat (3) @(negedge clk);
    chk("drain_dut0", 64'(q0.size()), 64'd0);
    chk("drain_dut1", 64'(q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
